// File: rtl/pkg_amba3.sv
`default_nettype none
// pkg_amba3: shared types for the AMBA3 APB requester arbiter.
package pkg_amba3;

  typedef enum logic [1:0] {
    APB_ARB_IDLE   = 2'd0,
    APB_ARB_SETUP  = 2'd1,
    APB_ARB_ACCESS = 2'd2
  } apb_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/amba3_rr_picker.sv
`default_nettype none
// amba3_rr_picker: combinational round-robin pick, first set request at or above ptr, wrapping.
module amba3_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_masked;
  int             w_first;

  // Upper copy keeps every bit so the wrap-around search lands there when the lower half is masked out.
  always_comb begin
    w_dbl    = {req, req};
    w_masked = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (i >= int'(ptr)) w_masked[i] = w_dbl[i];
    end
    w_first = 0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (w_masked[i]) w_first = i;
    end
  end

  assign any        = |req;
  assign gnt_idx    = IW'(w_first % N);
  assign gnt_onehot = any ? (N'(1) << gnt_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/amba3_apb_arbiter.sv
`default_nettype none
// amba3_apb_arbiter: shares one AMBA3 APB master port among NUM_REQ requesters, round-robin,
// with SETUP/ACCESS sequencing, pready wait and a bounded-wait timeout abort.
module amba3_apb_arbiter
  import pkg_amba3::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             rsp_done,
  output logic [DATA_SIZE-1:0]           rsp_rdata,
  output logic                           rsp_err,
  output logic [ADDR_SIZE-1:0]           paddr,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [DATA_SIZE-1:0]           pwdata,
  input  logic                           pready,
  input  logic [DATA_SIZE-1:0]           prdata
);

  localparam int            IW         = $clog2(NUM_REQ);
  localparam int            CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            C_TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] C_CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [IW-1:0] C_IDX_LAST = IW'(NUM_REQ - 1);

  apb_arb_state_e       r_state;
  apb_arb_state_e       w_state_nxt;

  logic [IW-1:0]        r_rr_ptr,   w_rr_ptr_nxt;
  logic [NUM_REQ-1:0]   r_gnt_oh,   w_gnt_oh_nxt;
  logic [CW-1:0]        r_cnt,      w_cnt_nxt;
  logic [ADDR_SIZE-1:0] r_paddr,    w_paddr_nxt;
  logic [DATA_SIZE-1:0] r_pwdata,   w_pwdata_nxt;
  logic                 r_psel,     w_psel_nxt;
  logic                 r_penable,  w_penable_nxt;
  logic                 r_pwrite,   w_pwrite_nxt;
  logic [NUM_REQ-1:0]   r_rsp_done, w_rsp_done_nxt;
  logic [DATA_SIZE-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                 r_rsp_err,  w_rsp_err_nxt;

  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_pick_any;
  logic                 w_timeout;
  logic                 w_complete;
  logic                 w_load;

  logic [ADDR_SIZE-1:0] w_addr_arr  [NUM_REQ];
  logic [DATA_SIZE-1:0] w_wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = req_addr[gi*ADDR_SIZE +: ADDR_SIZE];
    assign w_wdata_arr[gi] = req_wdata[gi*DATA_SIZE +: DATA_SIZE];
  end

  assign w_timeout  = C_TO_EN && (r_state == APB_ARB_ACCESS) && !pready && (r_cnt == C_CNT_LAST);
  assign w_complete = (r_state == APB_ARB_ACCESS) && (pready || w_timeout);

  // A requester still holding req_valid while being pulsed, or while finishing now, was already served.
  assign w_elig = req_valid & ~r_rsp_done & ~(w_complete ? r_gnt_oh : '0);

  amba3_rr_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req        (w_elig),
    .ptr        (r_rr_ptr),
    .gnt_onehot (w_pick_oh),
    .gnt_idx    (w_pick_idx),
    .any        (w_pick_any)
  );

  always_ff @(posedge pclk) begin
    if (!preset_n) r_state <= APB_ARB_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      APB_ARB_IDLE:   if (w_pick_any) w_state_nxt = APB_ARB_SETUP;
      APB_ARB_SETUP:  w_state_nxt = APB_ARB_ACCESS;
      APB_ARB_ACCESS: if (w_complete) w_state_nxt = w_pick_any ? APB_ARB_SETUP : APB_ARB_IDLE;
      default:        w_state_nxt = APB_ARB_IDLE;
    endcase
  end

  always_comb begin
    w_rr_ptr_nxt    = r_rr_ptr;
    w_gnt_oh_nxt    = r_gnt_oh;
    w_cnt_nxt       = r_cnt;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_rsp_done_nxt  = '0;
    w_rsp_rdata_nxt = '0;
    w_rsp_err_nxt   = 1'b0;
    w_load          = 1'b0;
    case (r_state)
      APB_ARB_IDLE: w_load = w_pick_any;
      APB_ARB_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
      end
      APB_ARB_ACCESS: begin
        if (w_complete) begin
          w_rsp_done_nxt  = r_gnt_oh;
          w_rsp_rdata_nxt = (pready && !r_pwrite) ? prdata : '0;
          w_rsp_err_nxt   = w_timeout;
          w_penable_nxt   = 1'b0;
          if (w_pick_any) begin
            w_load = 1'b1;
          end else begin
            w_psel_nxt   = 1'b0;
            w_paddr_nxt  = '0;
            w_pwrite_nxt = 1'b0;
            w_pwdata_nxt = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
    if (w_load) begin
      w_paddr_nxt   = w_addr_arr[w_pick_idx];
      w_pwrite_nxt  = req_write[w_pick_idx];
      w_pwdata_nxt  = req_write[w_pick_idx] ? w_wdata_arr[w_pick_idx] : '0;
      w_psel_nxt    = 1'b1;
      w_penable_nxt = 1'b0;
      w_gnt_oh_nxt  = w_pick_oh;
      w_rr_ptr_nxt  = (w_pick_idx == C_IDX_LAST) ? '0 : w_pick_idx + 1'b1;
      w_cnt_nxt     = '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_rr_ptr    <= '0;
      r_gnt_oh    <= '0;
      r_cnt       <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_rsp_done  <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_gnt_oh    <= w_gnt_oh_nxt;
      r_cnt       <= w_cnt_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_rsp_done  <= w_rsp_done_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign rsp_done  = r_rsp_done;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign paddr     = r_paddr;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_amba3_apb_arbiter.sv
`default_nettype none
// tb_amba3_apb_arbiter: random requesters and slave against a ticket-level arbitration model with a response scoreboard.
module tb_amba3_apb_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            preset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   paddr;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic            pready;
  logic [DW-1:0]   prdata;

  amba3_apb_arbiter #(
    .NUM_REQ   (N),
    .ADDR_SIZE (AW),
    .DATA_SIZE (DW),
    .TIMEOUT   (TO)
  ) dut (
    .pclk      (clk),
    .preset_n  (preset_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_done  (rsp_done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int            idx;
    logic [DW-1:0] rdata;
    logic          err;
    int            edge_at;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Requester tickets: one outstanding request per requester, visible to the arbiter from tk_vis on.
  logic          tk_valid [N];
  logic          tk_gnt   [N];
  int            tk_vis   [N];
  logic [AW-1:0] tk_addr  [N];
  logic          tk_wr    [N];
  logic [DW-1:0] tk_wdata [N];
  int            gap      [N];

  int            m_ptr;
  int            m_cur;
  int            m_gedge;
  int            m_dedge;
  logic          m_busy;
  logic          m_to;
  logic [DW-1:0] m_rdata;
  int            p_new;
  int            p_renew;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] el, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (el[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = tk_valid[i];
      req_write[i]          = tk_wr[i];
      req_addr[i*AW +: AW]  = tk_addr[i];
      req_wdata[i*DW +: DW] = tk_wdata[i];
    end
  endtask

  task automatic new_ticket(input int i, input int vis);
    tk_valid[i] = 1'b1;
    tk_gnt[i]   = 1'b0;
    tk_vis[i]   = vis;
    tk_wr[i]    = 1'($urandom_range(0, 1));
    tk_addr[i]  = AW'($urandom);
    tk_wdata[i] = DW'($urandom);
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_psel"},    64'(psel),    64'(0));
    chk({tag, "_penable"}, 64'(penable), 64'(0));
    chk({tag, "_paddr"},   64'(paddr),   64'(0));
    chk({tag, "_pwrite"},  64'(pwrite),  64'(0));
    chk({tag, "_pwdata"},  64'(pwdata),  64'(0));
  endtask

  // Called just after an edge at which preset_n was low.
  task automatic reset_step();
    chk_bus_idle("rst");
    chk("rst_rsp_done",  64'(rsp_done),  64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_err",   64'(rsp_err),   64'(0));
    m_busy = 1'b0;
    m_ptr  = 0;
    sb.delete();
    for (int i = 0; i < N; i++) tk_gnt[i] = 1'b0;
    drive_reqs();
    pready = 1'b0;
    prdata = '0;
  endtask

  // Called just after a normal edge: predict what that edge did, check the bus, then drive the next cycle.
  task automatic step();
    int            e;
    int            w;
    int            n;
    int            r;
    int            done_idx;
    logic          done_now;
    logic [N-1:0]  elig;
    e = edge_n;
    for (int i = 0; i < N; i++) elig[i] = tk_valid[i] && !tk_gnt[i] && (tk_vis[i] <= e);
    done_now = m_busy && (m_dedge == e);
    done_idx = m_cur;
    if (done_now) m_busy = 1'b0;
    if (!m_busy && (elig != '0)) begin
      w         = rr_pick(elig, m_ptr);
      tk_gnt[w] = 1'b1;
      m_ptr     = (w + 1) % N;
      m_cur     = w;
      m_busy    = 1'b1;
      m_gedge   = e;
      r         = int'($urandom_range(0, 19));
      m_to      = (r < 2);
      n         = (r < 3) ? TO : int'($urandom_range(1, 4));
      m_dedge   = e + 1 + n;
      m_rdata   = DW'($urandom);
      sb.push_back('{w, (!m_to && !tk_wr[w]) ? m_rdata : '0, m_to, m_dedge});
    end
    if (m_busy) begin
      chk("psel",    64'(psel),    64'(1));
      chk("penable", 64'(penable), 64'(e != m_gedge));
      chk("paddr",   64'(paddr),   64'(tk_addr[m_cur]));
      chk("pwrite",  64'(pwrite),  64'(tk_wr[m_cur]));
      chk("pwdata",  64'(pwdata),  64'(tk_wr[m_cur] ? tk_wdata[m_cur] : '0));
    end else begin
      chk_bus_idle("idle");
    end
    for (int i = 0; i < N; i++) begin
      if (done_now && (i == done_idx)) begin
        if (int'($urandom_range(0, 99)) < p_renew) begin
          new_ticket(i, e + 2);
        end else begin
          tk_valid[i] = 1'b0;
          gap[i]      = int'($urandom_range(0, 4));
        end
      end else if (!tk_valid[i]) begin
        if (gap[i] > 0) gap[i]--;
        else if (int'($urandom_range(0, 99)) < p_new) new_ticket(i, e + 1);
      end
    end
    drive_reqs();
    if (m_busy && (e + 1 >= m_gedge + 2)) begin
      pready = (e + 1 == m_dedge) && !m_to;
      prdata = (e + 1 == m_dedge) ? m_rdata : DW'($urandom);
    end else begin
      pready = 1'($urandom_range(0, 1));
      prdata = DW'($urandom);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_done != '0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: rsp_done=%b with no transfer outstanding (edge %0d)", rsp_done, edge_n);
        end else begin
          x = sb.pop_front();
          chk("rsp_done",  64'(rsp_done),  64'(N'(1) << x.idx));
          chk("rsp_edge",  64'(edge_n),    64'(x.edge_at));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(x.rdata));
          chk("rsp_err",   64'(rsp_err),   64'(x.err));
        end
      end else begin
        chk("rsp_rdata_quiet", 64'(rsp_rdata), 64'(0));
        chk("rsp_err_quiet",   64'(rsp_err),   64'(0));
        if ((sb.size() > 0) && (sb[0].edge_at <= edge_n)) begin
          tests++;
          fails++;
          $display("FAIL rsp_missing: no rsp_done, required rsp_done[%0d] at edge %0d (now %0d)",
                   sb[0].idx, sb[0].edge_at, edge_n);
          sb.delete(0);
        end
      end
    end
  end

  initial begin : stim
    logic found;
    preset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      tk_valid[i] = 1'b0;
      tk_gnt[i]   = 1'b0;
      tk_vis[i]   = 0;
      tk_addr[i]  = '0;
      tk_wr[i]    = 1'b0;
      tk_wdata[i] = '0;
      gap[i]      = 0;
    end
    m_ptr   = 0;
    m_cur   = 0;
    m_gedge = 0;
    m_dedge = 0;
    m_busy  = 1'b0;
    m_to    = 1'b0;
    m_rdata = '0;
    p_new   = 30;
    p_renew = 30;
    drive_reqs();
    pready = 1'b0;
    prdata = '0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    reset_step();
    preset_n = 1'b1;

    repeat (1500) begin
      @(posedge clk);
      #1;
      step();
    end

    p_new   = 100;
    p_renew = 100;
    repeat (300) begin
      @(posedge clk);
      #1;
      step();
    end

    found = 1'b0;
    for (int g = 0; (g < 400) && !found; g++) begin
      @(posedge clk);
      #1;
      step();
      if (m_busy && (edge_n + 1 >= m_gedge + 2) && (edge_n + 1 < m_dedge)) found = 1'b1;
    end
    chk("rst_window_found", 64'(found), 64'(1));
    if (found) begin
      preset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_step();
      preset_n = 1'b1;
    end

    repeat (200) begin
      @(posedge clk);
      #1;
      step();
    end

    p_new   = 20;
    p_renew = 40;
    repeat (800) begin
      @(posedge clk);
      #1;
      step();
    end

    p_new   = 0;
    p_renew = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      step();
    end
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
